// File: rtl/conv3x3_frame.sv
// Frame-aware dual-kernel 3x3 convolution over a raster pixel stream.
// Emits one saturated result per interior pixel, flagging the last result of each frame.
module conv3x3_frame #(
  parameter int unsigned linewidth_px_p = 16,
  parameter int unsigned height_px_p    = 16,
  parameter int unsigned in_width_p     = 8,
  parameter int unsigned out_width_p    = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [in_width_p-1:0]         data_i,
  input  logic [0:8][2:0]               weights_x_i,
  input  logic [0:8][2:0]               weights_y_i,
  input  logic [1:0]                    mode_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic signed [out_width_p-1:0] data_o,
  output logic                          last_o,
  output logic                          busy_o
);

  localparam int unsigned IntW  = in_width_p + 6;
  localparam int unsigned SumW  = IntW + 1;
  localparam int unsigned WideW = (SumW > out_width_p) ? SumW : out_width_p;
  localparam int unsigned ColW  = (linewidth_px_p > 1) ? $clog2(linewidth_px_p) : 1;
  localparam int unsigned RowW  = (height_px_p > 1) ? $clog2(height_px_p) : 1;

  localparam logic signed [WideW-1:0] SatMax =
    $signed({{(WideW - out_width_p + 1){1'b0}}, {(out_width_p - 1){1'b1}}});
  localparam logic signed [WideW-1:0] SatMin =
    $signed({{(WideW - out_width_p + 1){1'b1}}, {(out_width_p - 1){1'b0}}});

  logic [ColW-1:0]       col_q;
  logic [RowW-1:0]       row_q;
  logic                  busy_q;
  logic [1:0]            mode_q;
  logic [0:8][2:0]       wx_q, wy_q;
  logic                  valid_q, last_q;
  logic signed [out_width_p-1:0] data_q;

  logic [in_width_p-1:0] lb1_mem [linewidth_px_p];
  logic [in_width_p-1:0] lb2_mem [linewidth_px_p];
  logic [in_width_p-1:0] lb1_out, lb2_out;

  // Two stored columns; the third (newest) column comes straight from the inputs.
  logic [in_width_p-1:0] win_q [3][2];
  logic [in_width_p-1:0] cur   [3][3];

  logic accept, at_origin, col_end, row_end, frame_end, produce;

  logic signed [IntW-1:0]  px, gx, gy, ax, ay;
  logic signed [SumW-1:0]  res;
  logic signed [WideW-1:0] res_wide;
  logic signed [out_width_p-1:0] res_sat;

  assign ready_o   = ~valid_q | ready_i;
  assign accept    = valid_i & ready_o;
  assign at_origin = (col_q == '0) && (row_q == '0);
  assign col_end   = (col_q == ColW'(linewidth_px_p - 1));
  assign row_end   = (row_q == RowW'(height_px_p - 1));
  assign frame_end = col_end & row_end;
  assign produce   = (row_q >= RowW'(2)) && (col_q >= ColW'(2));

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;

  assign lb1_out = lb1_mem[col_q];
  assign lb2_out = lb2_mem[col_q];

  // Line-buffer RAM is deliberately left unreset; rows < 2 never produce output.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1_mem[col_q] <= data_i;
      lb2_mem[col_q] <= lb1_out;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      cur[r][0] = win_q[r][0];
      cur[r][1] = win_q[r][1];
    end
    cur[0][2] = lb2_out;
    cur[1][2] = lb1_out;
    cur[2][2] = data_i;
  end

  always_comb begin
    px = '0;
    gx = '0;
    gy = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px = $signed({{(IntW - in_width_p){1'b0}}, cur[r][c]});
        gx = gx + px * IntW'($signed(wx_q[r*3+c]));
        gy = gy + px * IntW'($signed(wy_q[r*3+c]));
      end
    end
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    unique case (mode_q)
      2'd1:    res = SumW'(ax) + SumW'(ay);
      2'd2:    res = (ax > ay) ? SumW'(ax) : SumW'(ay);
      default: res = SumW'(gx);
    endcase
    res_wide = WideW'(res);
    if (res_wide > SatMax) begin
      res_sat = out_width_p'(SatMax);
    end else if (res_wide < SatMin) begin
      res_sat = out_width_p'(SatMin);
    end else begin
      res_sat = out_width_p'(res_wide);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      mode_q  <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else begin
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= cur[r][1];
          win_q[r][1] <= cur[r][2];
        end
        if (col_end) begin
          col_q <= '0;
          row_q <= row_end ? '0 : row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
        if (frame_end) begin
          busy_q <= 1'b0;
        end else if (at_origin) begin
          busy_q <= 1'b1;
        end
        if (at_origin) begin
          mode_q <= mode_i;
          wx_q   <= weights_x_i;
          wy_q   <= weights_y_i;
        end
      end
      // Single-entry elastic output: a new result may replace one being consumed.
      if (accept && produce) begin
        valid_q <= 1'b1;
        data_q  <= res_sat;
        last_q  <= frame_end;
      end else if (ready_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_frame.sv
// Scoreboard bench for conv3x3_frame: a frame-level reference model queues expected
// results, an independent monitor checks every output handshake and stall hold.
module tb_conv3x3_frame;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int IW = 8;
  localparam int OW = 8;

  logic clk_i = 1'b0;
  logic reset_i, valid_i, ready_o, ready_i, valid_o, last_o, busy_o;
  logic [IW-1:0] data_i;
  logic [0:8][2:0] weights_x_i, weights_y_i;
  logic [1:0] mode_i;
  logic signed [OW-1:0] data_o;

  always #5 clk_i = ~clk_i;

  conv3x3_frame #(
    .linewidth_px_p(W),
    .height_px_p   (H),
    .in_width_p    (IW),
    .out_width_p   (OW)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .weights_x_i(weights_x_i),
    .weights_y_i(weights_y_i),
    .mode_i     (mode_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .last_o     (last_o),
    .busy_o     (busy_o)
  );

  typedef struct {int val; bit last;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  int checks = 0, errors = 0;
  int n_out = 0, n_exp = 0;
  int bp_mode = 0;   // 0 always ready, 1 random with stalls, 2 held low
  int stall_cnt = 0;
  bit gaps_on = 0;

  int frame_px[H][W];
  int fwx[9], fwy[9];
  int fmode;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: direct 2-D convolution over the stored frame, then mode and clamp.
  task automatic push_expected();
    int gx, gy, ax, ay, v;
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            gx += fwx[i*3+j] * frame_px[r-1+i][c-1+j];
            gy += fwy[i*3+j] * frame_px[r-1+i][c-1+j];
          end
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (fmode)
          1: v = ax + ay;
          2: v = (ax > ay) ? ax : ay;
          default: v = gx;
        endcase
        if (v > (1 << (OW - 1)) - 1) v = (1 << (OW - 1)) - 1;
        if (v < -(1 << (OW - 1))) v = -(1 << (OW - 1));
        exp_q.push_back('{val: v, last: (r == H - 2) && (c == W - 2)});
        n_exp++;
      end
    end
  endtask

  task automatic wait_accept();
    int t = 0;
    bit ok;
    do begin
      @(negedge clk_i);
      ok = ready_o;
      @(posedge clk_i);
      #1;
      t++;
    end while (!ok && t < 300);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, expected accept within 300 cycles");
    end
  endtask

  // Drives npix pixels of the stored frame; config inputs are garbage except at (0,0).
  task automatic send_frame(input int npix);
    for (int idx = 0; idx < npix; idx++) begin
      if (gaps_on && $urandom_range(0, 3) == 0) begin
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
      end
      valid_i = 1'b1;
      data_i  = IW'(frame_px[idx / W][idx % W]);
      for (int k = 0; k < 9; k++) begin
        weights_x_i[k] = (idx == 0) ? 3'(fwx[k]) : 3'($urandom);
        weights_y_i[k] = (idx == 0) ? 3'(fwy[k]) : 3'($urandom);
      end
      mode_i = (idx == 0) ? 2'(fmode) : 2'($urandom);
      wait_accept();
      if (idx == 0) check("busy_after_origin", int'(busy_o), 1);
    end
    valid_i = 1'b0;
  endtask

  task automatic set_sobel();
    int sx[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int sy[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    fwx = sx;
    fwy = sy;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame_px[r][c] = 10 * c;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++)
      frame_px[r][c] = int'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) begin
      fwx[k] = int'($urandom_range(0, 6)) - 3;
      fwy[k] = int'($urandom_range(0, 6)) - 3;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(posedge clk_i);
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk_i);
    #1;
    check("busy_idle_after_frame", int'(busy_o), 0);
  endtask

  // Downstream ready generator.
  initial begin
    ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (bp_mode)
        0: ready_i = 1'b1;
        1: begin
          if (stall_cnt == 0 && $urandom_range(0, 19) == 0) stall_cnt = 5;
          if (stall_cnt > 0) begin
            ready_i = 1'b0;
            stall_cnt--;
          end else begin
            ready_i = ($urandom_range(0, 2) != 0);
          end
        end
        default: ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: pops one expectation per output handshake; checks holds under stall.
  bit hold_v = 0;
  int hold_d;
  int hold_l;
  always @(negedge clk_i) begin
    if (reset_i) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        check("stall_valid_held", int'(valid_o), 1);
        check("stall_data_held", int'(data_o), hold_d);
        check("stall_last_held", int'(last_o), hold_l);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data %0d, expected no output", data_o);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'(data_o), e.val);
          check("out_last", int'(last_o), int'(e.last));
          n_out++;
        end
      end
      hold_v = valid_o && !ready_i;
      hold_d = int'(data_o);
      hold_l = int'(last_o);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i = '0;
    weights_x_i = '0;
    weights_y_i = '0;
    mode_i = '0;
    #12;
    check("reset_valid", int'(valid_o), 0);
    check("reset_last", int'(last_o), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_data", int'(data_o), 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("reset_ready", int'(ready_o), 1);

    // Flat frame -> zeros; then ramp in all three modes, back to back.
    set_sobel();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame_px[r][c] = 10;
    fmode = 0;
    push_expected();
    send_frame(W * H);
    fill_ramp();
    for (int m = 0; m < 3; m++) begin
      fmode = m;
      push_expected();
      send_frame(W * H);
    end

    // Saturation at both rails.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame_px[r][c] = (c < 2) ? 0 : 255;
    fmode = 0;
    push_expected();
    send_frame(W * H);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame_px[r][c] = (c < 2) ? 255 : 0;
    push_expected();
    send_frame(W * H);
    drain();

    // Backpressure with input gaps: ramp plus random frames in every mode.
    bp_mode = 1;
    gaps_on = 1;
    set_sobel();
    fill_ramp();
    fmode = 0;
    push_expected();
    send_frame(W * H);
    for (int f = 0; f < 8; f++) begin
      fill_random();
      fmode = f % 4;
      push_expected();
      send_frame(W * H);
    end
    drain();

    // Abort mid-frame with a result held, then a clean ramp frame.
    bp_mode = 2;
    gaps_on = 0;
    @(posedge clk_i);
    #1;
    fill_random();
    fmode = 0;
    send_frame(2 * W + 3);
    #2;
    reset_i = 1'b1;
    #1;
    check("abort_busy", int'(busy_o), 0);
    check("abort_valid", int'(valid_o), 0);
    check("abort_last", int'(last_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    bp_mode = 0;
    @(posedge clk_i);
    #1;
    set_sobel();
    fill_ramp();
    fmode = 0;
    push_expected();
    send_frame(W * H);
    drain();

    // Back-to-back mode 1 then mode 0 under stalls, then random gapped frames.
    bp_mode = 1;
    fill_random();
    fmode = 1;
    push_expected();
    send_frame(W * H);
    fmode = 0;
    push_expected();
    send_frame(W * H);
    gaps_on = 1;
    for (int f = 0; f < 6; f++) begin
      fill_random();
      fmode = int'($urandom_range(0, 3));
      push_expected();
      send_frame(W * H);
    end
    drain();

    check("total_outputs", n_out, n_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
